// File: rtl/adc_scan_ctrl.sv
// ADC128S022 SPI scan master: cycles channels 5,6,7 and publishes 12-bit results atomically.
// Latency: first commit 16 + 4*256 cycles after enable; then one commit every 768 cycles.
// Flow: no backpressure; en is sampled only at frame boundaries, results update on scan_done.
module adc_scan_ctrl #(
  parameter int CLK_DIV = 16
) (
  input  logic        clk_50,
  input  logic        rst,
  input  logic        en,
  input  logic        adc_dout,
  output logic        adc_cs_n,
  output logic        adc_sck,
  output logic        adc_din,
  output logic [11:0] ch5,
  output logic [11:0] ch6,
  output logic [11:0] ch7,
  output logic [1:0]  data_frame,
  output logic        scan_done
);

  localparam int DW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV / 2);
  localparam logic [DW-1:0] DIV_SAMP = DW'(3 * CLK_DIV / 4);

  typedef enum logic {IDLE, CONV} state_t;

  state_t          state, state_nxt;
  logic [DW-1:0]   div, div_nxt;
  logic [DW-1:0]   hi_cnt;
  logic [3:0]      bitn, bit_nxt;
  logic [1:0]      addr_idx, addr_nxt;   // 0,1,2 -> ADC address 5,6,7
  logic            first;                // frame 0 after entering CONV: data is discarded
  logic            start, frame_end, commit;
  logic [2:0]      addr_bits;
  logic [7:0]      ctrl_byte;
  logic            sck_nxt, din_nxt;
  logic            dout_s1, dout_s2;
  logic [11:0]     rx, s5, s6;

  assign start     = (state == IDLE) && en && (hi_cnt == DIV_LAST);
  assign frame_end = (state == CONV) && (div == DIV_LAST) && (bitn == 4'd15);
  // the frame addressed 5 carries channel 7 data, except for the discarded frame 0
  assign commit    = frame_end && !first && (addr_idx == 2'd0);

  // state register
  always_ff @(posedge clk_50) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // next state, bit position and the serial outputs they imply
  always_comb begin
    state_nxt = state;
    div_nxt   = div;
    bit_nxt   = bitn;
    addr_nxt  = addr_idx;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = CONV;
          div_nxt   = '0;
          bit_nxt   = 4'd0;
          addr_nxt  = 2'd0;
        end
      end
      CONV: begin
        if (div == DIV_LAST) begin
          div_nxt = '0;
          bit_nxt = bitn + 4'd1;
          if (bitn == 4'd15) begin
            addr_nxt = (addr_idx == 2'd2) ? 2'd0 : addr_idx + 2'd1;
            if (!en) state_nxt = IDLE;
          end
        end else begin
          div_nxt = div + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
    addr_bits = 3'd5 + {1'b0, addr_nxt};
    ctrl_byte = {2'b00, addr_bits, 3'b000};
    sck_nxt   = 1'b1;
    din_nxt   = 1'b0;
    if (state_nxt == CONV) begin
      sck_nxt = (div_nxt >= DIV_HALF);
      din_nxt = !bit_nxt[3] && ctrl_byte[~bit_nxt[2:0]];
    end
  end

  // bit timing counters, serial pins and the cs_n high-time guard
  always_ff @(posedge clk_50) begin
    if (rst) begin
      div      <= '0;
      bitn     <= 4'd0;
      addr_idx <= 2'd0;
      hi_cnt   <= '0;
      first    <= 1'b0;
      adc_cs_n <= 1'b1;
      adc_sck  <= 1'b1;
      adc_din  <= 1'b0;
    end else begin
      div      <= div_nxt;
      bitn     <= bit_nxt;
      addr_idx <= addr_nxt;
      adc_cs_n <= (state_nxt == IDLE);
      adc_sck  <= sck_nxt;
      adc_din  <= din_nxt;
      if (state != IDLE || state_nxt != IDLE) hi_cnt <= '0;
      else if (hi_cnt != DIV_LAST)            hi_cnt <= hi_cnt + 1'b1;
      if (start)          first <= 1'b1;
      else if (frame_end) first <= 1'b0;
    end
  end

  // receive path: 2-flop synchronizer, sample at 3/4 period, shadow and commit
  always_ff @(posedge clk_50) begin
    if (rst) begin
      dout_s1    <= 1'b0;
      dout_s2    <= 1'b0;
      rx         <= '0;
      s5         <= '0;
      s6         <= '0;
      ch5        <= '0;
      ch6        <= '0;
      ch7        <= '0;
      data_frame <= 2'd0;
      scan_done  <= 1'b0;
    end else begin
      dout_s1   <= adc_dout;
      dout_s2   <= dout_s1;
      scan_done <= 1'b0;
      if (state == CONV && div == DIV_SAMP && bitn >= 4'd4)
        rx <= {rx[10:0], dout_s2};
      if (frame_end && !first) begin
        if (addr_idx == 2'd1) s5 <= rx;
        if (addr_idx == 2'd2) s6 <= rx;
      end
      if (commit) begin
        ch5       <= s5;
        ch6       <= s6;
        ch7       <= rx;
        scan_done <= 1'b1;
      end
      // IDLE entry wins over a simultaneous commit so a stopped scanner reads 0
      if (frame_end) begin
        if (!en)                     data_frame <= 2'd0;
        else if (commit)             data_frame <= 2'd1;
        else if (data_frame != 2'd0) data_frame <= data_frame + 2'd1;
      end
    end
  end

endmodule

// File: doc/adc_scan_ctrl.md
# adc_scan_ctrl

SPI master for the on-board ADC128S022 that continuously scans the three line-sensor channels (5, 6, 7) and publishes their 12-bit results. It is the producer end of the sensor interface consumed by the line-follower block: it generates the ADC serial clock, which also drives the follower's `adc_clk` input, and it supplies the `ch5`/`ch6`/`ch7` words and the `data_frame` phase indicator. All result updates are atomic, so consumers never see a mix of old and new channel values.

## Interface
- `CLK_DIV`, 16: clk_50 cycles per adc_sck period; must be even; 16 gives 3.125 MHz.
- `clk_50`  in  1  system clock, 50 MHz.
- `rst`  in  1  synchronous, active-high reset.
- `en`  in  1  scan enable; sampled at frame boundaries.
- `adc_dout`  in  1  ADC serial data out (MISO), asynchronous to clk_50.
- `adc_cs_n`  out  1  ADC chip select, active low.
- `adc_sck`  out  1  ADC serial clock; idles high; also feeds the follower's adc_clk.
- `adc_din`  out  1  ADC serial data in (MOSI).
- `ch5`, `ch6`, `ch7`  out  12  latest committed channel results.
- `data_frame`  out  2  0 means no valid scan yet or stopped; 1/2/3 is the frame index since the last commit.
- `scan_done`  out  1  one-cycle pulse on each commit.

## Operation
- Reset (synchronous, active-high) puts the outputs in these states:
  - `adc_cs_n`=1, `adc_sck`=1, `adc_din`=0.
  - `ch5`/`ch6`/`ch7`=0, `data_frame`=0, `scan_done`=0.
  - FSM state is IDLE.
- The FSM has two states.
  - IDLE: `adc_cs_n` high and `adc_sck` high. Leave IDLE for CONV when `en`=1 and `adc_cs_n` has been high for at least `CLK_DIV` cycles. The frame counter restarts at frame 0.
  - CONV: runs back-to-back 16-bit frames with `adc_cs_n` held low continuously. At the end of each frame, if `en`=0, return to IDLE, otherwise start the next frame.
- Bit timing:
  - A divider counts `div`=0..CLK_DIV-1, and each frame covers bits 0..15.
  - `adc_sck` is low for div 0..CLK_DIV/2-1 and high for the rest of the period.
  - The falling edge coincides with div=0, and `adc_din` updates on that same cycle.
- `adc_din` sequence per frame, MSB first:
  - Bits 0..7 carry the control byte 0,0,A2,A1,A0,0,0,0.
  - Bits 8..15 are 0.
- Address rotation: frame k sends address A_k from the cycle 5,6,7,5,6,7,… with frame 0 sending 5.
- Pipeline: the data in frame k belongs to A_{k-1}.
  - Frame 0 data is the power-on channel 0 and is discarded.
  - Frame with A=6 carries channel 5 data, A=7 carries channel 6, A=5 (k≥3) carries channel 7.
- Receive path:
  - `adc_dout` passes through a 2-flop synchronizer.
  - The synchronized value is sampled at div=3·CLK_DIV/4 of each bit.
  - Bits 0..3 are leading zeros and are ignored. Bits 4..15 form the result, MSB first.
  - Results go into shadow registers `s5`, `s6`.
- Commit happens on the final sample of every frame that carries channel 7 data. On that cycle:
  - `ch5`←s5, `ch6`←s6, `ch7`←shift result.
  - `scan_done` pulses for 1 cycle.
  - `data_frame`←1.
- `data_frame` increments 1→2→3 at each subsequent frame start; a commit always returns it to 1. It is 0 until the first commit.
- Stop: dropping `en` mid-frame completes that frame, including any commit, then returns to IDLE.
  - `data_frame`←0 on the IDLE entry.
  - `ch*` hold their values.
  - Restarting from IDLE discards frame 0 again.
- Simultaneous `rst` and any other event: `rst` wins.
  - Reset mid-frame aborts the frame.
  - `adc_cs_n` rises on the next edge.
  - No partial commit occurs.

## Timing
- adc_sck period is `CLK_DIV` cycles, and a frame is 16·CLK_DIV cycles (256).
- A full scan is 3 frames, i.e. 768 cycles between commits.
- Edge numbering: edge 1 is the first rising clk_50 edge with `rst`=0.
  - With `en`=1 from reset, `adc_cs_n` falls at edge 16 (CLK_DIV).
  - The first `scan_done` pulse is at edge 16+4·256=1040.
  - Later pulses follow every 768 cycles.
- `adc_din` is stable from a falling sck edge until the next falling edge, so it is valid at the ADC's rising-edge latch.
- Sampling `adc_dout` at 3/4 of the period, after 2 sync cycles, stays within the ADC's post-falling-edge valid window.
- All outputs are registered; there is no combinational path from input to output.

## Test plan
- **Reset:** hold `rst` 5 cycles mid-scan.
  - Next edge shows `adc_cs_n`=1, `adc_sck`=1, `ch*`=0, `data_frame`=0.
  - No `scan_done` pulse for the first 1039 edges after release.
- **First scan:** ADC model returns 0x300 for ch5, 0x500 for ch6, 0xABC for ch7.
  - `scan_done` pulses at edge 1040.
  - `ch5`=0x300, `ch6`=0x500, `ch7`=0xABC all change on the same edge.
  - `data_frame`=1.
- **Address stream:** capture `adc_din` on the rising edges of `adc_sck`.
  - Control bytes read 0x28, 0x30, 0x38, 0x28 in frames 0..3.
  - Bits 8..15 of every frame are 0.
- **Atomic update:** change model values to 0x123/0x456/0x789 mid-scan.
  - Outputs stay at the old values until the next `scan_done`, then all three change on that edge.
  - `data_frame` runs 1,2,3,1 at 256-cycle spacing.
- **Stop/restart:** drop `en` at bit 5 of a ch7-carrying frame.
  - The commit still occurs, then `adc_cs_n` rises at the frame end and `data_frame`=0.
  - Re-raise `en`: the next commit comes 16+4·256 cycles after IDLE entry, and frame 0 data (model channel 0 = 0xFFF) never appears on any `ch*`.
- **MSB/leading-zero check:** the model drives 1s on leading bits 0..3 with ch6=0x800.
  - `ch6`=0x800, showing the leading bits are ignored.
